// File: rtl/alu_pkg.sv
// Shared encodings and types for the ALU command sequencer.
// Command word layout is {sweep, op, a, b}, 9 bits.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHF = 2'b10;
  localparam logic [1:0] OP_EQ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    OUT   = 2'b10
  } state_t;

  typedef struct packed {
    logic       sweep;
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, head visible combinationally on dout.
// Writes ignored when full and reads ignored when empty; full/empty come from the registered count.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Time-shares the ALU between queued commands: pop, drive operands for SETTLE cycles, capture result.
// Result port holds res_* until res_ready; sweep mode steps ops 00..11 on one operand pair.
module alu_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  input  logic       cmd_sweep,
  output logic [1:0] alu_sel,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [3:0] alu_q,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_op,
  output logic       res_last,
  output logic       busy
);

  import alu_pkg::*;

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  state_t        state_q;
  state_t        state_d;
  cmd_t          cmd_in;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [1:0]    op_r;
  logic [2:0]    a_r;
  logic [2:0]    b_r;
  logic          sweep_r;
  logic [CW-1:0] cnt;

  assign cmd_in    = '{sweep: cmd_sweep, op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  // Operand registers drive the ALU directly, so the buses hold their last values outside DRIVE.
  assign alu_sel = op_r;
  assign alu_a   = a_r;
  assign alu_b   = b_r;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) state_d = OUT;
      end
      OUT: begin
        if (res_ready) state_d = (sweep_r && op_r != OP_EQ) ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= OP_ADD;
      a_r       <= '0;
      b_r       <= '0;
      sweep_r   <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= OP_ADD;
      res_last  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            op_r    <= head.sweep ? OP_ADD : head.op;
            a_r     <= head.a;
            b_r     <= head.b;
            sweep_r <= head.sweep;
            cnt     <= CNT_INIT;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            res_data  <= alu_q;
            res_op    <= op_r;
            res_last  <= !sweep_r || (op_r == OP_EQ);
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (sweep_r && op_r != OP_EQ) begin
              op_r <= op_r + 1'b1;
              cnt  <= CNT_INIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU stub on the alu_* buses.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic       cmd_sweep;
  logic [1:0] alu_sel;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [3:0] alu_q;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_op;
  logic       res_last;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_sequencer #(.DEPTH(4), .SETTLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sweep (cmd_sweep),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_q     (alu_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_last  (res_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: add, a-b, a<<1, bitwise equality zero-extended.
  always_comb begin
    case (alu_sel)
      2'b00:   alu_q = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_q = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_q = {alu_a, 1'b0};
      default: alu_q = {1'b0, ~(alu_a ^ alu_b)};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic sweep);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sweep = sweep;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!res_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 32'(res_valid), 32'd1);
  endtask

  logic [3:0] sweep_exp [4];
  logic [3:0] full_exp  [5];
  logic [1:0] full_op   [5];
  logic [2:0] full_a    [5];
  logic [2:0] full_b    [5];

  initial begin
    sweep_exp = '{4'h4, 4'h0, 4'h4, 4'h7};
    full_op   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    full_a    = '{3'd1, 3'd6, 3'd3, 3'd5, 3'd7};
    full_b    = '{3'd1, 3'd1, 3'd0, 3'd5, 3'd7};
    full_exp  = '{4'h2, 4'h5, 4'h6, 4'h7, 4'he};

    rst_n     = 1'b0;
    res_ready = 1'b0;
    send(2'b00, 3'd7, 3'd7, 1'b0);
    tick(); tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);

    // Single add: accepted at the first edge, ALU driven after the second, result after the third.
    send(2'b00, 3'd3, 3'd5, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("add_busy", 32'(busy), 32'd1);
    tick();
    chk("add_alu_sel", 32'(alu_sel), 32'd0);
    chk("add_alu_a", 32'(alu_a), 32'd3);
    chk("add_alu_b", 32'(alu_b), 32'd5);
    chk("add_early_valid", 32'(res_valid), 32'd0);
    tick();
    chk("add_res_valid", 32'(res_valid), 32'd1);
    chk("add_res_data", 32'(res_data), 32'h8);
    chk("add_res_op", 32'(res_op), 32'd0);
    chk("add_res_last", 32'(res_last), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("add_valid_clr", 32'(res_valid), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);

    // Backpressure with a second command queued behind the stalled one.
    send(2'b01, 3'd5, 3'd3, 1'b0);
    tick();
    send(2'b11, 3'd1, 3'd1, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_res_data", 32'(res_data), 32'h2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_data", 32'(res_data), 32'h2);
      chk("bp_hold_op", 32'(res_op), 32'd1);
      chk("bp_no_issue", 32'(alu_sel), 32'd1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_valid_clr", 32'(res_valid), 32'd0);
    chk("bp_busy_queued", 32'(busy), 32'd1);
    tick();
    chk("bp_next_sel", 32'(alu_sel), 32'd3);
    chk("bp_next_a", 32'(alu_a), 32'd1);
    tick();
    chk("bp_next_valid", 32'(res_valid), 32'd1);
    chk("bp_next_data", 32'(res_data), 32'h7);
    chk("bp_next_op", 32'(res_op), 32'd3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Sweep: op field is ignored, four results in op order, last flag only on op 11.
    res_ready = 1'b1;
    send(2'b10, 3'd2, 3'd2, 1'b1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("sw_timeout", 6);
      chk("sw_res_op", 32'(res_op), 32'(k));
      chk("sw_res_data", 32'(res_data), 32'(sweep_exp[k]));
      chk("sw_res_last", 32'(res_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("sw_done_valid", 32'(res_valid), 32'd0);
    tick();
    chk("sw_done_busy", 32'(busy), 32'd0);
    res_ready = 1'b0;

    // Full FIFO: first command pops into the FSM, four more fill the queue.
    for (int i = 0; i < 5; i++) begin
      send(full_op[i], full_a[i], full_b[i], 1'b0);
      chk("full_ready_before", 32'(cmd_ready), 32'd1);
      tick();
    end
    send(2'b00, 3'd0, 3'd0, 1'b0);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    tick(); tick();
    chk("full_ready_held", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("full_timeout", 6);
      chk("full_res_data", 32'(res_data), 32'(full_exp[i]));
      chk("full_res_op", 32'(res_op), 32'(full_op[i]));
      tick();
    end
    tick(); tick();
    chk("full_no_extra", 32'(res_valid), 32'd0);
    chk("full_drained_busy", 32'(busy), 32'd0);
    res_ready = 1'b0;

    // Async reset in the middle of a sweep, during DRIVE of op 01.
    res_ready = 1'b1;
    send(2'b00, 3'd2, 3'd2, 1'b1);
    tick();
    cmd_valid = 1'b0;
    wait_valid("ar_timeout", 6);
    chk("ar_first_data", 32'(res_data), 32'h4);
    tick();
    chk("ar_drive_sel", 32'(alu_sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_res_valid", 32'(res_valid), 32'd0);
    chk("ar_res_data", 32'(res_data), 32'd0);
    chk("ar_alu_sel", 32'(alu_sel), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_no_result", 32'(res_valid), 32'd0);
    end
    chk("ar_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
